io_switch_debouncer: RTL

- Input stage directly upstream of the MIPS memory-mapped IO read path.
- Takes raw board switches (snake speed switches, WIDTH bits), synchronises them to CLK and debounces them per bit.
- Presents debounced levels and sticky change flags on IOReadData, selected by IOAddr.
- Replaces the direct switch-to-IOReadData connection in the top level.
- Flags are cleared by software through the existing IOWriteEn/IOWriteData path.

---
 rtl/io_switch_debouncer_if.sv | 22 ++
 rtl/io_switch_debouncer.sv | 106 ++++++++++
 2 files changed

// File: rtl/io_switch_debouncer_if.sv
// MIPS memory-mapped IO bus as seen by the switch debouncer.
// The CPU side drives address and write signals, and the peripheral drives read data.
interface io_switch_debouncer_if;
    logic [3:0]  IOAddr;
    logic        IOWriteEn;
    logic [31:0] IOWriteData;
    logic [31:0] IOReadData;

    modport master (
        output IOAddr,
        output IOWriteEn,
        output IOWriteData,
        input  IOReadData
    );

    modport slave (
        input  IOAddr,
        input  IOWriteEn,
        input  IOWriteData,
        output IOReadData
    );
endinterface

// File: rtl/io_switch_debouncer.sv
// Switch synchroniser, debouncer and IO read mux with write-1-to-clear change flags.
// Defining SWITCH_CHANGE_IRQ_EN adds the registered CHANGE_IRQ output (OR of all flags).
module io_switch_debouncer #(
    parameter int         WIDTH         = 2,
    parameter int         STABLE_CYCLES = 100000,
    parameter int         CNT_W         = 17,
    parameter logic [3:0] LEVEL_ADDR    = 4'h4,
    parameter logic [3:0] FLAG_ADDR     = 4'h5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      SW_IN,
    io_switch_debouncer_if.slave  io,
`ifdef SWITCH_CHANGE_IRQ_EN
    output logic                  CHANGE_IRQ,
`endif
    output logic [WIDTH-1:0]      SW_LEVEL
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] flag;
    logic [WIDTH-1:0] done;
    logic [WIDTH-1:0] clr;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [31:0]      rdata;
    logic             unused_wdata;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= SW_IN;
            sync2 <= sync1;
        end
    end

    always_comb begin
        done = '0;
        for (int i = 0; i < WIDTH; i++) begin
            done[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // Any sample matching the accepted level restarts the count.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                cnt[g]    <= '0;
                stable[g] <= 1'b0;
            end else if (sync2[g] == stable[g]) begin
                cnt[g]    <= '0;
            end else if (done[g]) begin
                cnt[g]    <= '0;
                stable[g] <= sync2[g];
            end else begin
                cnt[g]    <= cnt[g] + 1'b1;
            end
        end
    end

    always_comb begin
        clr = '0;
        if (io.IOWriteEn && (io.IOAddr == FLAG_ADDR)) begin
            clr = io.IOWriteData[WIDTH-1:0];
        end
    end

    assign unused_wdata = ^io.IOWriteData[31:WIDTH];

    // A completing debounce outranks a same-cycle software clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            flag <= '0;
        end else begin
            flag <= done | (flag & ~clr);
        end
    end

`ifdef SWITCH_CHANGE_IRQ_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            CHANGE_IRQ <= 1'b0;
        end else begin
            CHANGE_IRQ <= |flag;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (io.IOAddr == LEVEL_ADDR): rdata = 32'(stable);
            (io.IOAddr == FLAG_ADDR):  rdata = 32'(flag);
            default:                   rdata = '0;
        endcase
    end

    assign io.IOReadData = rdata;
    assign SW_LEVEL      = stable;

endmodule
